// File: rtl/serial_byte_loader_if.sv
// Handshake and data bundle between a serial bit source and serial_byte_loader.
// The master drives the request/serial side and the slave (the loader) drives
// the assembled byte and its status flags.
interface serial_byte_loader_if;
    logic       Start;
    logic       BitEn;
    logic       SerIn;
    logic       Ack;
    logic [7:0] OUT;
    logic       Valid;
    logic       Busy;
    logic       ParErr;

    modport master (
        output Start, BitEn, SerIn, Ack,
        input  OUT, Valid, Busy, ParErr
    );

    modport slave (
        input  Start, BitEn, SerIn, Ack,
        output OUT, Valid, Busy, ParErr
    );
endinterface

// File: rtl/serial_byte_loader.sv
// serial_byte_loader: assembles eight qualified serial bits into a byte and
// holds it (Valid=1) until the downstream register acknowledges it.
// Optional feature macro: SBL_PARITY_EN adds a trailing even-parity bit and
// drives ParErr; with the macro undefined ParErr is tied low.
//
// state  | meaning
// IDLE   | waiting for Start, OUT keeps the last byte
// SHIFT  | consuming data bits on BitEn, Busy=1
// PARITY | consuming the parity bit (SBL_PARITY_EN only), Busy=1
// HOLD   | byte complete, Valid=1, waiting for Ack
module serial_byte_loader #(
    parameter int MSB_FIRST = 1
) (
    input logic               Clk,
    input logic               Clear,
    serial_byte_loader_if.slave bus
);

`ifdef SBL_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
`endif

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] out_q;
    logic       valid_q;
    logic       busy_q;
    logic [7:0] shifted;

    // Next shift-register value for the configured bit order.
    always_comb begin
        shifted = out_q;
        if (MSB_FIRST != 0)
            shifted = {out_q[6:0], bus.SerIn};
        else
            shifted = {bus.SerIn, out_q[7:1]};
    end

`ifdef SBL_PARITY_EN
    logic par_err_q;
`endif

    // Capture FSM with registered outputs.
    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            out_q   <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SBL_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state   <= SHIFT;
                        bit_cnt <= 3'd0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.BitEn) begin
                        out_q   <= shifted;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef SBL_PARITY_EN
                            state <= PARITY;
`else
                            state   <= HOLD;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
`endif
                        end
                    end
                end
`ifdef SBL_PARITY_EN
                PARITY: begin
                    if (bus.BitEn) begin
                        state     <= HOLD;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        // Even parity: data bits plus parity bit must XOR to 0.
                        par_err_q <= (^out_q) ^ bus.SerIn;
                    end
                end
`endif
                HOLD: begin
                    if (bus.Ack) begin
                        valid_q <= 1'b0;
`ifdef SBL_PARITY_EN
                        par_err_q <= 1'b0;
`endif
                        if (bus.Start) begin
                            // Back-to-back byte: skip IDLE entirely.
                            state   <= SHIFT;
                            bit_cnt <= 3'd0;
                            busy_q  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.OUT   = out_q;
    assign bus.Valid = valid_q;
    assign bus.Busy  = busy_q;
`ifdef SBL_PARITY_EN
    assign bus.ParErr = par_err_q;
`else
    assign bus.ParErr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_loader.sv
// Self-checking bench for serial_byte_loader: directed scenarios plus a
// randomized loop, checked against a transaction-level model of the loader.
module tb_serial_byte_loader;
    localparam int MSB = 1;

    logic Clk;
    logic Clear;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] last_byte;

    serial_byte_loader_if bus ();

    serial_byte_loader #(.MSB_FIRST(MSB)) dut (
        .Clk   (Clk),
        .Clear (Clear),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Bit sent at position i (0 = first) so that the loader reconstructs d.
    function automatic logic tx_bit(input logic [7:0] d, input int i);
        if (MSB != 0) return d[7-i];
        return d[i];
    endfunction

    function automatic logic exp_par_err(input logic [7:0] d, input logic pbit);
`ifdef SBL_PARITY_EN
        return (^d) ^ pbit;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_start();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        check("start_busy", bus.Busy, 1);
        check("start_valid", bus.Valid, 0);
    endtask

    // Sends one byte (plus parity bit if enabled) with optional stalls and
    // spurious Start/Ack noise; checks status every cycle and the result.
    task automatic send_byte(input logic [7:0] d, input logic pbit,
                             input int stall_at, input int stall_len, input bit noise);
        int nbits;
`ifdef SBL_PARITY_EN
        nbits = 9;
`else
        nbits = 8;
`endif
        for (int i = 0; i < nbits; i++) begin
            int st;
            st = 0;
            if (i == stall_at) st = stall_len;
            else if (noise && $urandom_range(0, 3) == 0) st = int'($urandom_range(1, 3));
            for (int s = 0; s < st; s++) begin
                bus.BitEn = 1'b0;
                bus.SerIn = 1'($urandom);
                bus.Start = noise ? 1'($urandom) : 1'b0;
                bus.Ack   = noise ? 1'($urandom) : 1'b0;
                tick();
                check("stall_busy", bus.Busy, 1);
                check("stall_valid", bus.Valid, 0);
            end
            bus.BitEn = 1'b1;
            bus.SerIn = (i < 8) ? tx_bit(d, i) : pbit;
            bus.Start = noise ? 1'($urandom) : 1'b0;
            bus.Ack   = noise ? 1'($urandom) : 1'b0;
            tick();
            bus.BitEn = 1'b0;
            bus.Start = 1'b0;
            bus.Ack   = 1'b0;
            if (i < nbits - 1) begin
                check("shift_busy", bus.Busy, 1);
                check("shift_valid", bus.Valid, 0);
            end
        end
        check("byte_out", bus.OUT, d);
        check("byte_valid", bus.Valid, 1);
        check("byte_busy", bus.Busy, 0);
        check("byte_parerr", bus.ParErr, exp_par_err(d, pbit));
        last_byte = d;
    endtask

    task automatic hold_check(input int n, input bit noise);
        for (int k = 0; k < n; k++) begin
            bus.Start = noise ? 1'($urandom) : 1'b0;
            bus.Ack   = 1'b0;
            bus.BitEn = 1'($urandom);
            bus.SerIn = 1'($urandom);
            tick();
            check("hold_valid", bus.Valid, 1);
            check("hold_busy", bus.Busy, 0);
            check("hold_out", bus.OUT, last_byte);
        end
        bus.Start = 1'b0;
        bus.BitEn = 1'b0;
    endtask

    task automatic do_ack(input bit with_start);
        bus.Ack   = 1'b1;
        bus.Start = with_start;
        bus.BitEn = 1'b0;
        tick();
        bus.Ack   = 1'b0;
        bus.Start = 1'b0;
        check("ack_valid", bus.Valid, 0);
        check("ack_busy", bus.Busy, 32'(with_start));
        check("ack_parerr", bus.ParErr, 0);
        check("ack_out", bus.OUT, last_byte);
    endtask

    task automatic idle_check(input int n);
        for (int k = 0; k < n; k++) begin
            bus.Start = 1'b0;
            bus.Ack   = 1'($urandom);
            bus.BitEn = 1'($urandom);
            bus.SerIn = 1'($urandom);
            tick();
            check("idle_busy", bus.Busy, 0);
            check("idle_valid", bus.Valid, 0);
            check("idle_out", bus.OUT, last_byte);
        end
        bus.Ack   = 1'b0;
        bus.BitEn = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       pb;
        bit         chained;

        bus.Start = 1'b0;
        bus.BitEn = 1'b0;
        bus.SerIn = 1'b0;
        bus.Ack   = 1'b0;
        Clear     = 1'b1;
        last_byte = 8'h00;
        #2 Clear = 1'b0;
        tick();
        tick();
        check("rst_out", bus.OUT, 8'h00);
        check("rst_valid", bus.Valid, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_parerr", bus.ParErr, 0);
        Clear = 1'b1;

        // Basic byte, held until Ack.
        do_start();
        send_byte(8'hF6, ^8'hF6, -1, 0, 1'b0);
        hold_check(3, 1'b0);
        do_ack(1'b0);
        idle_check(2);

        // Three-cycle stall after bit 4.
        do_start();
        send_byte(8'h55, ^8'h55, 4, 3, 1'b0);
        hold_check(1, 1'b0);
        do_ack(1'b0);

        // Asynchronous clear mid-capture after five bits.
        do_start();
        d = 8'h9C;
        for (int i = 0; i < 5; i++) begin
            bus.BitEn = 1'b1;
            bus.SerIn = tx_bit(d, i);
            tick();
        end
        bus.BitEn = 1'b0;
        #2 Clear = 1'b0;
        #1;
        check("clr_out", bus.OUT, 8'h00);
        check("clr_valid", bus.Valid, 0);
        check("clr_busy", bus.Busy, 0);
        check("clr_parerr", bus.ParErr, 0);
        tick();
        tick();
        Clear = 1'b1;
        last_byte = 8'h00;
        idle_check(6);
        do_start();
        send_byte(8'hA3, ^8'hA3, -1, 0, 1'b0);

        // Ack with Start in HOLD: back-to-back byte.
        do_ack(1'b1);
        send_byte(8'h0F, ^8'h0F, -1, 0, 1'b0);
        hold_check(2, 1'b1);
        do_ack(1'b0);

        // Spurious Start during SHIFT and Ack in IDLE.
        idle_check(3);
        do_start();
        send_byte(8'hC9, ^8'hC9, -1, 0, 1'b1);
        do_ack(1'b0);

`ifdef SBL_PARITY_EN
        do_start();
        send_byte(8'hF6, 1'b0, -1, 0, 1'b0);
        check("par_ok", bus.ParErr, 0);
        do_ack(1'b0);
        do_start();
        send_byte(8'hF6, 1'b1, -1, 0, 1'b0);
        check("par_bad", bus.ParErr, 1);
        check("par_bad_valid", bus.Valid, 1);
        do_ack(1'b0);
`endif

        // Randomized transactions.
        chained = 1'b0;
        for (int t = 0; t < 40; t++) begin
            d  = 8'($urandom);
            pb = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            if (!chained) do_start();
            send_byte(d, pb, -1, 0, 1'b1);
            hold_check(int'($urandom_range(0, 3)), 1'b1);
            chained = 1'($urandom);
            do_ack(chained);
            if (!chained) idle_check(int'($urandom_range(0, 2)));
        end
        if (chained) begin
            send_byte(8'h3C, ^8'h3C, -1, 0, 1'b0);
            do_ack(1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
